// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle core: opcodes, sequencer states,
// instruction field positions and register index folding.
package cpu_pkg;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_AND   = 3'd4;
  localparam logic [2:0] OP_OR    = 3'd5;
  localparam logic [2:0] OP_BEQ   = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 29;
  localparam int RD_HI  = 28;
  localparam int RD_LO  = 24;
  localparam int RS1_HI = 23;
  localparam int RS1_LO = 19;
  localparam int RS2_HI = 18;
  localparam int RS2_LO = 14;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_HALTED
  } state_t;

  // 5-bit register field folded into the implemented register count.
  function automatic logic [4:0] reg_sel(input logic [4:0] field, input int unsigned num_regs);
    return 5'(32'(field) % num_regs);
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: three asynchronous read ports, one synchronous write port.
// Register 0 reads as zero and ignores writes.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1_field,
  input  logic [4:0]        rs2_field,
  input  logic [4:0]        rd_field,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [4:0]        wr_field,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [4:0] sel_rs1, sel_rs2, sel_rd, sel_wr;

  assign sel_rs1 = reg_sel(rs1_field, NUM_REGS);
  assign sel_rs2 = reg_sel(rs2_field, NUM_REGS);
  assign sel_rd  = reg_sel(rd_field, NUM_REGS);
  assign sel_wr  = reg_sel(wr_field, NUM_REGS);

  assign rs1_data = (sel_rs1 == 5'd0) ? '0 : regs[sel_rs1];
  assign rs2_data = (sel_rs2 == 5'd0) ? '0 : regs[sel_rs2];
  assign rd_data  = (sel_rd == 5'd0)  ? '0 : regs[sel_rd];

  // Storage: cleared on reset, written on enable except for register 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en && (sel_wr != 5'd0)) begin
      regs[sel_wr] <= wr_data;
    end
  end

endmodule

// File: rtl/multicycle_cpu_core.sv
// Multicycle CPU core with external instruction/data memories on
// req/ready handshakes. Requests are registered and held until accepted.
//
// state       | meaning
// ------------+--------------------------------------------------------
// S_FETCH     | imem_req held until imem_ready; latch instr, pc+1
// S_DECODE    | read rs1/rs2/rd operands from the register file
// S_EXECUTE   | ALU/address compute; BEQ and HALT retire here
// S_MEMORY    | dmem_req held until dmem_ready; STORE retires here
// S_WRITEBACK | write rd, retire
// S_HALTED    | no requests, pc frozen; left only by reset
module multicycle_cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted
);

  state_t state, state_next;

  logic [31:0]       instr;
  logic [DATA_W-1:0] op_a, op_b, op_d, result;
  logic [DATA_W-1:0] rs1_data, rs2_data, rd_data;
  logic [DATA_W-1:0] alu_res;
  logic [ADDR_W-1:0] mem_addr_calc, branch_tgt;
  logic [2:0]        opcode;
  logic              fetch_done, mem_done, retire_c;

  assign opcode        = instr[OP_HI:OP_LO];
  assign fetch_done    = imem_req && imem_ready;
  assign mem_done      = dmem_req && dmem_ready;
  assign mem_addr_calc = op_a[ADDR_W-1:0] + instr[ADDR_W-1:0];
  // Lower ADDR_W bits of the sign-extended offset give the same wrapped target.
  assign branch_tgt    = pc + instr[ADDR_W-1:0];

  assign imem_addr = pc;
  assign retire    = retire_c;
  assign halted    = (state == S_HALTED);

  cpu_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_field(instr[RS1_HI:RS1_LO]),
    .rs2_field(instr[RS2_HI:RS2_LO]),
    .rd_field (instr[RD_HI:RD_LO]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_data  (rd_data),
    .wr_en    (state == S_WRITEBACK),
    .wr_field (instr[RD_HI:RD_LO]),
    .wr_data  (result)
  );

  // ALU: combinational on the latched operands.
  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      default: alu_res = '0;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Next-state and retire decode.
  always_comb begin
    state_next = state;
    retire_c   = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (fetch_done) state_next = S_DECODE;
      end
      S_DECODE: state_next = S_EXECUTE;
      S_EXECUTE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMORY;
          OP_BEQ: begin
            retire_c   = 1'b1;
            state_next = S_FETCH;
          end
          OP_HALT: begin
            retire_c   = 1'b1;
            state_next = S_HALTED;
          end
          default: state_next = S_WRITEBACK;
        endcase
      end
      S_MEMORY: begin
        if (mem_done) begin
          if (opcode == OP_STORE) begin
            retire_c   = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        retire_c   = 1'b1;
        state_next = S_FETCH;
      end
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_FETCH;
    endcase
  end

  // Datapath and registered handshake outputs; requests rise on entry to
  // their state so a zero-wait access completes in a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      instr      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_d       <= '0;
      result     <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      imem_req <= (state_next == S_FETCH);
      dmem_req <= (state_next == S_MEMORY);
      case (state)
        S_FETCH: begin
          if (fetch_done) begin
            instr <= imem_rdata;
            pc    <= pc + ADDR_W'(1);
          end
        end
        S_DECODE: begin
          op_a <= rs1_data;
          op_b <= rs2_data;
          op_d <= rd_data;
        end
        S_EXECUTE: begin
          result <= alu_res;
          if (opcode == OP_LOAD || opcode == OP_STORE) begin
            dmem_addr  <= mem_addr_calc;
            dmem_we    <= (opcode == OP_STORE);
            dmem_wdata <= op_d;
          end
          if (opcode == OP_BEQ && op_d == op_a) pc <= branch_tgt;
        end
        S_MEMORY: begin
          if (mem_done) begin
            dmem_we <= 1'b0;
            if (opcode == OP_LOAD) result <= dmem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu_core.sv
module tb_multicycle_cpu_core;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req, imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              dmem_req, dmem_we, dmem_ready;
  logic [ADDR_W-1:0] dmem_addr, pc;
  logic [DATA_W-1:0] dmem_wdata, dmem_rdata;
  logic              retire, halted;

  multicycle_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  // Memory models with programmable wait states.
  logic [31:0] imem [64];
  logic [31:0] dmem [16];
  int imem_wait = 0, dmem_wait = 0;
  int icnt = 0, dcnt = 0;

  assign imem_ready = imem_req && (icnt >= imem_wait);
  assign dmem_ready = dmem_req && (dcnt >= dmem_wait);
  assign imem_rdata = imem[imem_addr[5:0]];
  assign dmem_rdata = dmem[dmem_addr[3:0]];

  // Monitor: cycle/retire counts, fetch and store logs, handshake stability.
  int cyc, n_retire, n_fetch, n_store, n_dacc, dreq_edges;
  logic started, dreq_prev, ihold, dhold, iunstable, dunstable;
  logic [ADDR_W-1:0] ihold_addr, dhold_addr;
  logic [DATA_W-1:0] dhold_data;
  logic dhold_we;
  logic [ADDR_W-1:0] fetch_log [16];
  logic [ADDR_W-1:0] st_addr [8];
  logic [DATA_W-1:0] st_data [8];

  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
    if (rst) begin
      cyc <= 0; n_retire <= 0; n_fetch <= 0; n_store <= 0; n_dacc <= 0; dreq_edges <= 0;
      started <= 1'b0; dreq_prev <= 1'b0; ihold <= 1'b0; dhold <= 1'b0;
      iunstable <= 1'b0; dunstable <= 1'b0;
    end else begin
      if (imem_req) started <= 1'b1;
      if ((started || imem_req) && !halted) cyc <= cyc + 1;
      if (retire) n_retire <= n_retire + 1;
      if (imem_req && imem_ready) begin
        if (n_fetch < 16) fetch_log[n_fetch] <= imem_addr;
        n_fetch <= n_fetch + 1;
      end
      ihold <= imem_req && !imem_ready;
      ihold_addr <= imem_addr;
      if (ihold && (!imem_req || imem_addr != ihold_addr)) iunstable <= 1'b1;
      dhold <= dmem_req && !dmem_ready;
      dhold_addr <= dmem_addr; dhold_data <= dmem_wdata; dhold_we <= dmem_we;
      if (dhold && (!dmem_req || dmem_addr != dhold_addr || dmem_wdata != dhold_data || dmem_we != dhold_we))
        dunstable <= 1'b1;
      dreq_prev <= dmem_req;
      if (dmem_req && !dreq_prev) dreq_edges <= dreq_edges + 1;
      if (dmem_req && dmem_ready) begin
        n_dacc <= n_dacc + 1;
        if (dmem_we) begin
          if (n_store < 8) begin
            st_addr[n_store] <= dmem_addr;
            st_data[n_store] <= dmem_wdata;
          end
          n_store <= n_store + 1;
        end
      end
    end
  end

  int tests = 0, failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [15:0] imm);
    return {op, rd, rs1, 19'b0} | ({27'b0, rs2} << 14) | {16'b0, imm};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = {3'd7, 29'b0};
  endtask

  task automatic load_prog_basic();
    clear_imem();
    imem[0] = enc(3'd0, 5'd1, 5'd0, 5'd0, 16'd4);
    imem[1] = enc(3'd0, 5'd2, 5'd0, 5'd0, 16'd5);
    imem[2] = enc(3'd2, 5'd3, 5'd1, 5'd2, 16'd0);
    imem[3] = enc(3'd3, 5'd4, 5'd1, 5'd2, 16'd0);
    imem[4] = enc(3'd7, 5'd0, 5'd0, 5'd0, 16'd0);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    for (int k = 0; k < budget && !halted; k++) @(negedge clk);
    check("halt_reached", halted, 1'b1);
  endtask

  task automatic wait_fetches(input int n, input int budget);
    for (int k = 0; k < budget && n_fetch < n; k++) @(negedge clk);
    check("fetch_count", 64'(n_fetch >= n), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
    dmem[4] = 32'd7; dmem[5] = 32'd5; dmem[6] = 32'd1;
    clear_imem();

    // Reset state
    #1;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_dmem_req", dmem_req, 1'b0);
    check("rst_pc", pc, 16'd0);
    check("rst_retire", retire, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_dmem_we", dmem_we, 1'b0);

    // Zero-wait basic program
    load_prog_basic();
    do_reset();
    wait_halt(100);
    check("p0_cycles", 64'(cyc), 64'd21);
    check("p0_retires", 64'(n_retire), 64'd5);
    check("p0_r3", dut.u_regfile.regs[3], 32'd12);
    check("p0_r4", dut.u_regfile.regs[4], 32'd2);
    repeat (3) @(negedge clk);
    check("p0_pc_frozen", pc, 16'd5);
    check("p0_no_req", 64'({imem_req, dmem_req}), 64'd0);
    check("p0_retire_quiet", 64'(n_retire), 64'd5);

    // Three-cycle fetch waits
    imem_wait = 3;
    do_reset();
    wait_halt(200);
    check("p1_cycles", 64'(cyc), 64'd36);
    check("p1_retires", 64'(n_retire), 64'd5);
    check("p1_r3", dut.u_regfile.regs[3], 32'd12);
    check("p1_r4", dut.u_regfile.regs[4], 32'd2);
    check("p1_ireq_stable", iunstable, 1'b0);

    // Reset asserted while a fetch is pending
    imem_wait = 0;
    do_reset();
    for (int k = 0; k < 50 && n_retire < 1; k++) @(negedge clk);
    imem_wait = 1000;
    repeat (3) @(negedge clk);
    check("mid_req_pending", imem_req, 1'b1);
    check("mid_pc_before", pc, 16'd1);
    rst = 1'b1;
    #1;
    check("mid_req_async", imem_req, 1'b0);
    check("mid_pc_async", pc, 16'd0);
    @(negedge clk);
    check("mid_req_next", imem_req, 1'b0);
    imem_wait = 0;
    rst = 1'b0;
    wait_fetches(1, 20);
    check("mid_first_fetch", fetch_log[0], 16'd0);
    wait_halt(100);

    // Taken BEQ self-loop at pc=10
    clear_imem();
    imem[0]  = enc(3'd6, 5'd0, 5'd0, 5'd0, 16'd9);
    imem[10] = enc(3'd6, 5'd1, 5'd1, 5'd0, 16'hFFFF);
    do_reset();
    wait_fetches(4, 100);
    check("beq_t_f1", fetch_log[1], 16'd10);
    check("beq_t_f2", fetch_log[2], 16'd10);
    check("beq_t_f3", fetch_log[3], 16'd10);

    // Not-taken BEQ at pc=10
    clear_imem();
    imem[0]  = enc(3'd0, 5'd1, 5'd0, 5'd0, 16'd4);
    imem[1]  = enc(3'd6, 5'd0, 5'd0, 5'd0, 16'd8);
    imem[10] = enc(3'd6, 5'd1, 5'd0, 5'd0, 16'hFFFF);
    do_reset();
    wait_halt(100);
    check("beq_nt_f2", fetch_log[2], 16'd10);
    check("beq_nt_f3", fetch_log[3], 16'd11);
    check("beq_nt_pc", pc, 16'd12);

    // pc wrap from 0xFFFF on a non-branch
    clear_imem();
    imem[0]  = enc(3'd6, 5'd0, 5'd0, 5'd0, 16'hFFFE);
    imem[63] = enc(3'd2, 5'd3, 5'd0, 5'd0, 16'd0);
    do_reset();
    wait_fetches(3, 100);
    check("wrap_f1", fetch_log[1], 16'hFFFF);
    check("wrap_f2", fetch_log[2], 16'h0000);

    // Stores, r0 discard, SUB underflow, data waits
    clear_imem();
    imem[0]  = enc(3'd0, 5'd1, 5'd0, 5'd0, 16'd4);
    imem[1]  = enc(3'd0, 5'd2, 5'd0, 5'd0, 16'd5);
    imem[2]  = enc(3'd0, 5'd7, 5'd0, 5'd0, 16'd6);
    imem[3]  = enc(3'd2, 5'd3, 5'd1, 5'd2, 16'd0);
    imem[4]  = enc(3'd2, 5'd0, 5'd1, 5'd2, 16'd0);
    imem[5]  = enc(3'd2, 5'd5, 5'd0, 5'd0, 16'd0);
    imem[6]  = enc(3'd3, 5'd6, 5'd0, 5'd7, 16'd0);
    imem[7]  = enc(3'd1, 5'd3, 5'd0, 5'd0, 16'hFFFF);
    imem[8]  = enc(3'd1, 5'd5, 5'd0, 5'd0, 16'd8);
    imem[9]  = enc(3'd1, 5'd6, 5'd0, 5'd0, 16'd9);
    dmem_wait = 2;
    do_reset();
    wait_halt(300);
    check("st_cycles", 64'(cyc), 64'd58);
    check("st_retires", 64'(n_retire), 64'd11);
    check("st_count", 64'(n_store), 64'd3);
    check("st_accesses", 64'(n_dacc), 64'd6);
    check("st_req_edges", 64'(dreq_edges), 64'd6);
    check("st_dreq_stable", dunstable, 1'b0);
    check("st0_addr", st_addr[0], 16'hFFFF);
    check("st0_data", st_data[0], 32'd12);
    check("st1_addr", st_addr[1], 16'd8);
    check("st1_r5", st_data[1], 32'd0);
    check("st2_r6", st_data[2], 32'hFFFF_FFFF);
    check("st_pc", pc, 16'd11);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
